// File: rtl/uart_reg_responder.sv
// Byte-command responder on the user side of a UART FIFO pair: 'W' addr data / 'R' addr against a small register file.
// Replies one byte per frame. Frames that stall mid-way are dropped after an inter-byte timeout.
module uart_reg_responder #(
  parameter int NREG_AW   = 2,
  parameter int TO_CYCLES = 1000000,
  parameter int TO_W      = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_empty,
  input  logic [7:0]                  r_data,
  output logic                        rd_uart,
  input  logic                        tx_full,
  output logic                        wr_uart,
  output logic [7:0]                  w_data,
  output logic [8*(2**NREG_AW)-1:0]   regs,
  output logic                        busy,
  output logic [7:0]                  err_cnt
);

  localparam int NREG = 2**NREG_AW;
  localparam logic [7:0] CMD_W     = 8'h57;
  localparam logic [7:0] CMD_R     = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;
  localparam logic [7:0] RSP_RANGE = 8'h21;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SEND} state_t;

  state_t                   state_q;
  logic [7:0]               cmd_q;
  logic [7:0]               addr_q;
  logic [7:0]               resp_q;
  logic [TO_W-1:0]          to_cnt_q;
  logic [NREG-1:0][7:0]     regs_q;
  logic [7:0]               err_cnt_q;

  logic in_frame;
  logic rx_addr_ok;
  logic q_addr_ok;
  logic rx_is_cmd;
  logic timeout;
  logic err_inc;

  assign in_frame   = (state_q == ADDR) || (state_q == DATA);
  assign rx_addr_ok = ((r_data >> NREG_AW) == 8'd0);
  assign q_addr_ok  = ((addr_q >> NREG_AW) == 8'd0);
  assign rx_is_cmd  = (r_data == CMD_W) || (r_data == CMD_R);
  assign timeout    = in_frame && rx_empty && (to_cnt_q == TO_LAST);

  assign rd_uart = ~reset & ~rx_empty & (state_q != SEND);
  assign wr_uart = ~reset & ~tx_full  & (state_q == SEND);
  assign w_data  = resp_q;
  assign busy    = (state_q != IDLE);
  assign regs    = regs_q;
  assign err_cnt = err_cnt_q;

  // All error sources are mutually exclusive within a cycle, so one increment suffices.
  always_comb begin
    err_inc = 1'b0;
    if (rd_uart) begin
      unique case (state_q)
        IDLE:    err_inc = ~rx_is_cmd;
        ADDR:    err_inc = (cmd_q == CMD_R) && ~rx_addr_ok;
        DATA:    err_inc = ~q_addr_ok;
        default: err_inc = 1'b0;
      endcase
    end else if (timeout) begin
      err_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      resp_q    <= 8'h00;
      to_cnt_q  <= '0;
      regs_q    <= '0;
      err_cnt_q <= 8'h00;
    end else begin
      if (err_inc && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;

      unique case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (rd_uart) begin
            if (rx_is_cmd) begin
              cmd_q   <= r_data;
              state_q <= ADDR;
            end else begin
              resp_q  <= RSP_BAD;
              state_q <= SEND;
            end
          end
        end
        ADDR: begin
          if (rd_uart) begin
            to_cnt_q <= '0;
            addr_q   <= r_data;
            if (cmd_q == CMD_R) begin
              resp_q  <= rx_addr_ok ? regs_q[r_data[NREG_AW-1:0]] : RSP_RANGE;
              state_q <= SEND;
            end else begin
              state_q <= DATA;
            end
          end else if (timeout) begin
            to_cnt_q <= '0;
            state_q  <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (rd_uart) begin
            to_cnt_q <= '0;
            if (q_addr_ok) begin
              regs_q[addr_q[NREG_AW-1:0]] <= r_data;
              resp_q <= RSP_OK;
            end else begin
              resp_q <= RSP_RANGE;
            end
            state_q <= SEND;
          end else if (timeout) begin
            to_cnt_q <= '0;
            state_q  <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        SEND: begin
          to_cnt_q <= '0;
          if (wr_uart)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: queue-backed rx FIFO model, tx capture, hand-computed expectations.
module tb_uart_reg_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic [31:0] regs;
  logic        busy;
  logic [7:0]  err_cnt;

  uart_reg_responder #(.NREG_AW(2), .TO_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .regs(regs), .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, pops = 0, last_pop = 0, last_wr = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // rx FIFO model (first-word fall-through) and tx capture; updates land 1ns after the edge.
  always @(posedge clk) begin
    logic popped;
    logic [7:0] dummy;
    cyc++;
    popped = rd_uart;
    if (rd_uart) begin pops++; last_pop = cyc; end
    if (wr_uart) begin txq.push_back(w_data); last_wr = cyc; end
    #1;
    if (popped && rxq.size() > 0) dummy = rxq.pop_front();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  end

  task automatic push2(input logic [7:0] a, input logic [7:0] b);
    rxq.push_back(a);
    rxq.push_back(b);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (txq.size() < n && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    check_eq(tag, txq.size(), n);
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pops < n && k < 200) begin @(negedge clk); k++; end
    check_eq(tag, pops, n);
  endtask

  initial begin
    int p0;
    logic bad;
    reset = 1'b1; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;

    // Frame queued while reset is held: nothing may be popped yet.
    repeat (2) @(negedge clk);
    push2(8'h57, 8'h02); rxq.push_back(8'hA5);
    repeat (2) @(negedge clk);
    check_eq("rst_rx_nonempty", rx_empty, 0);
    check_eq("rst_rd_uart", rd_uart, 0);
    check_eq("rst_wr_uart", wr_uart, 0);
    check_eq("rst_w_data", w_data, 8'h00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_regs", regs, 32'h0);
    check_eq("rst_err", err_cnt, 0);
    reset = 1'b0;

    // 1: write reg 2
    wait_tx(1, "t1_tx_count");
    check_eq("t1_resp", txq[0], 8'h4B);
    check_eq("t1_regs", regs, 32'h00A5_0000);
    check_eq("t1_busy", busy, 0);

    // 2: read back, response one cycle after the final pop
    push2(8'h52, 8'h02);
    wait_tx(2, "t2_tx_count");
    check_eq("t2_resp", txq[1], 8'hA5);
    check_eq("t2_latency", last_wr - last_pop, 1);
    check_eq("t2_regs", regs, 32'h00A5_0000);

    // 3: bad command, then out-of-range read
    rxq.push_back(8'h58);
    wait_tx(3, "t3_tx_count_a");
    check_eq("t3_bad_cmd", txq[2], 8'h3F);
    check_eq("t3_err1", err_cnt, 1);
    push2(8'h52, 8'h07);
    wait_tx(4, "t3_tx_count_b");
    check_eq("t3_range", txq[3], 8'h21);
    check_eq("t3_err2", err_cnt, 2);
    check_eq("t3_regs", regs, 32'h00A5_0000);

    // 4: stalled write frame times out silently
    p0 = pops;
    push2(8'h57, 8'h01);
    wait_pops(p0 + 2, "t4_pops");
    @(negedge clk);
    check_eq("t4_busy_mid", busy, 1);
    begin
      int k = 0;
      while (busy && k < 40) begin @(negedge clk); k++; end
    end
    check_eq("t4_busy_drop", busy, 0);
    check_eq("t4_err3", err_cnt, 3);
    check_eq("t4_no_tx", txq.size(), 4);
    push2(8'h52, 8'h01);
    wait_tx(5, "t4_tx_count");
    check_eq("t4_read_after_to", txq[4], 8'h00);

    // 5: tx_full stalls SEND; queued frame must not be popped meanwhile
    tx_full = 1'b1;
    p0 = pops;
    push2(8'h52, 8'h02); push2(8'h52, 8'h02);
    wait_pops(p0 + 2, "t5_pops");
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (wr_uart || rd_uart || rx_empty || !busy) bad = 1'b1;
    end
    check_eq("t5_stall_clean", bad, 0);
    check_eq("t5_stall_pops", pops, p0 + 2);
    tx_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_single_pulse", txq.size(), 6);
    wait_tx(7, "t5_tx_count");
    check_eq("t5_resp_a", txq[5], 8'hA5);
    check_eq("t5_resp_b", txq[6], 8'hA5);

    // 6: reset in DATA clears everything
    p0 = pops;
    push2(8'h57, 8'h03);
    wait_pops(p0 + 2, "t6_pops");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("t6_regs", regs, 32'h0);
    check_eq("t6_err", err_cnt, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_no_tx", txq.size(), 7);
    push2(8'h52, 8'h03);
    wait_tx(8, "t6_tx_count");
    check_eq("t6_read3", txq[7], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
